// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32I immediate generator with a two-entry output buffer.
// The opcode is decoded on the way in, so the stored data is the final
// immediate, format code and illegal flag. Entry 0 drives out_*; the skid
// entry absorbs one extra beat when downstream stalls. This lets in_ready
// be a plain flop, so no combinational path crosses the block.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | no beat held, out_valid low
// ST_ONE   | entry 0 holds a beat, skid empty
// ST_TWO   | entry 0 and skid both hold beats, in_ready low
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_in_ready;

    logic [XLEN-1:0]  w_imm;
    logic [2:0]       w_fmt;
    logic             w_illegal;
    logic             w_sign;

    logic [XLEN-1:0]  r_e0_imm;
    logic [2:0]       r_e0_fmt;
    logic             r_e0_illegal;
    logic [TAG_W-1:0] r_e0_tag;
    logic [XLEN-1:0]  r_e1_imm;
    logic [2:0]       r_e1_fmt;
    logic             r_e1_illegal;
    logic [TAG_W-1:0] r_e1_tag;

    logic w_acc;
    logic w_emit;
    logic w_ld_e0_dec;
    logic w_ld_e0_skid;
    logic w_ld_e1;

    assign w_sign = in_instr[31];
    assign w_acc  = in_valid & r_in_ready;
    assign w_emit = (r_state != ST_EMPTY) & out_ready;

    // Decode the incoming opcode into format, illegal flag and scaled immediate.
    always_comb begin
        w_imm     = '0;
        w_fmt     = FMT_ILL;
        w_illegal = 1'b1;
        case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
                w_fmt     = FMT_I;
                w_illegal = 1'b0;
                w_imm     = {{(XLEN-11){w_sign}}, in_instr[30:20]};
            end
            7'b0100011: begin
                w_fmt     = FMT_S;
                w_illegal = 1'b0;
                w_imm     = {{(XLEN-11){w_sign}}, in_instr[30:25], in_instr[11:7]};
            end
            7'b1100011: begin
                w_fmt     = FMT_B;
                w_illegal = 1'b0;
                w_imm     = {{(XLEN-12){w_sign}}, in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_fmt     = FMT_U;
                w_illegal = 1'b0;
                w_imm     = {{(XLEN-31){w_sign}}, in_instr[30:12], 12'b0};
            end
            7'b1101111: begin
                w_fmt     = FMT_J;
                w_illegal = 1'b0;
                w_imm     = {{(XLEN-20){w_sign}}, in_instr[19:12], in_instr[20],
                             in_instr[30:21], 1'b0};
            end
            7'b0110011: begin
                w_fmt     = FMT_R;
                w_illegal = 1'b0;
                w_imm     = '0;
            end
            default: begin
                w_fmt     = FMT_ILL;
                w_illegal = 1'b1;
                w_imm     = '0;
            end
        endcase
    end

    // Occupancy state and the registered in_ready (skid empty after this edge).
    always_ff @(posedge clk) begin
        if (res) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
        end
    end

    // Next occupancy from the accept/emit handshakes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: w_state_nxt = w_acc ? ST_ONE : ST_EMPTY;
            ST_ONE: begin
                if (w_acc && !w_emit)
                    w_state_nxt = ST_TWO;
                else if (!w_acc && w_emit)
                    w_state_nxt = ST_EMPTY;
                else
                    w_state_nxt = ST_ONE;
            end
            ST_TWO:   w_state_nxt = w_emit ? ST_ONE : ST_TWO;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Entry load strobes; accept is impossible in ST_TWO since in_ready is low.
    always_comb begin
        w_ld_e0_dec  = 1'b0;
        w_ld_e0_skid = 1'b0;
        w_ld_e1      = 1'b0;
        case (r_state)
            ST_EMPTY: w_ld_e0_dec = w_acc;
            ST_ONE: begin
                w_ld_e0_dec = w_acc & w_emit;
                w_ld_e1     = w_acc & ~w_emit;
            end
            ST_TWO:   w_ld_e0_skid = w_emit;
            default: begin
                w_ld_e0_dec  = 1'b0;
                w_ld_e0_skid = 1'b0;
                w_ld_e1      = 1'b0;
            end
        endcase
    end

    // Storage for entry 0 (output) and entry 1 (skid); reset clears both.
    always_ff @(posedge clk) begin
        if (res) begin
            r_e0_imm     <= '0;
            r_e0_fmt     <= '0;
            r_e0_illegal <= 1'b0;
            r_e0_tag     <= '0;
            r_e1_imm     <= '0;
            r_e1_fmt     <= '0;
            r_e1_illegal <= 1'b0;
            r_e1_tag     <= '0;
        end else begin
            if (w_ld_e0_dec) begin
                r_e0_imm     <= w_imm;
                r_e0_fmt     <= w_fmt;
                r_e0_illegal <= w_illegal;
                r_e0_tag     <= in_tag;
            end else if (w_ld_e0_skid) begin
                r_e0_imm     <= r_e1_imm;
                r_e0_fmt     <= r_e1_fmt;
                r_e0_illegal <= r_e1_illegal;
                r_e0_tag     <= r_e1_tag;
            end
            if (w_ld_e1) begin
                r_e1_imm     <= w_imm;
                r_e1_fmt     <= w_fmt;
                r_e1_illegal <= w_illegal;
                r_e1_tag     <= in_tag;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_state != ST_EMPTY);
    assign out_imm     = r_e0_imm;
    assign out_fmt     = r_e0_fmt;
    assign out_illegal = r_e0_illegal;
    assign out_tag     = r_e0_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit and a 64-bit instance share stimulus and
// are checked against a queue-based reference model on every cycle.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [7:0]  in_tag = '0;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic [7:0]  out_tag;

    logic        q_in_ready, q_out_valid, q_out_illegal;
    logic [63:0] q_out_imm;
    logic [2:0]  q_out_fmt;
    logic [7:0]  q_out_tag;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc = 0;
    int n_emit = 0;

    logic [39:0] sb_q[$];

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
        .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
        .clk(clk), .res(res), .in_valid(in_valid), .in_ready(q_in_ready),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(q_out_valid),
        .out_ready(out_ready), .out_imm(q_out_imm), .out_fmt(q_out_fmt),
        .out_illegal(q_out_illegal), .out_tag(q_out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: format from opcode class, immediate as a signed value.
    function automatic logic [2:0] m_fmt(input logic [31:0] i);
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: return 3'd1;
            7'h23:                      return 3'd2;
            7'h63:                      return 3'd3;
            7'h37, 7'h17:               return 3'd4;
            7'h6F:                      return 3'd5;
            7'h33:                      return 3'd0;
            default:                    return 3'd7;
        endcase
    endfunction

    function automatic logic [63:0] m_imm(input logic [31:0] i);
        logic [63:0] hi;
        hi = i[31] ? ~64'h0 : 64'h0;
        case (m_fmt(i))
            3'd1: return (hi << 11) | 64'(i[30:20]);
            3'd2: return (hi << 11) | (64'(i[30:25]) << 5) | 64'(i[11:7]);
            3'd3: return (hi << 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5)
                         | (64'(i[11:8]) << 1);
            3'd4: return (hi << 31) | (64'(i[30:12]) << 12);
            3'd5: return (hi << 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11)
                         | (64'(i[30:21]) << 1);
            default: return 64'h0;
        endcase
    endfunction

    // Per-cycle compare: occupancy, stall stability, and in-order scoreboard.
    logic        stall_prev = 1'b0;
    logic [63:0] h_imm64;
    logic [31:0] h_imm32;
    logic [2:0]  h_fmt;
    logic        h_ill;
    logic [7:0]  h_tag;

    always @(negedge clk) begin
        logic [39:0] ent;
        logic [63:0] e_imm;
        logic [31:0] e_imm32;
        if (res) begin
            sb_q.delete();
            stall_prev = 1'b0;
        end else begin
            chk("occ_out_valid32", out_valid, sb_q.size() > 0);
            chk("occ_out_valid64", q_out_valid, sb_q.size() > 0);
            chk("occ_in_ready32", in_ready, sb_q.size() < 2);
            chk("occ_in_ready64", q_in_ready, sb_q.size() < 2);
            if (stall_prev && out_valid) begin
                chk("stall_imm32", out_imm, h_imm32);
                chk("stall_imm64", q_out_imm, h_imm64);
                chk("stall_fmt", out_fmt, h_fmt);
                chk("stall_illegal", out_illegal, h_ill);
                chk("stall_tag", out_tag, h_tag);
            end
            if (out_valid && out_ready) begin
                n_emit++;
                if (sb_q.size() == 0) begin
                    chk("emit_without_accept", 64'd1, 64'd0);
                end else begin
                    ent = sb_q.pop_front();
                    e_imm = m_imm(ent[31:0]);
                    e_imm32 = e_imm[31:0];
                    chk("sb_imm32", out_imm, e_imm32);
                    chk("sb_imm64", q_out_imm, e_imm);
                    chk("sb_fmt32", out_fmt, m_fmt(ent[31:0]));
                    chk("sb_fmt64", q_out_fmt, m_fmt(ent[31:0]));
                    chk("sb_illegal", out_illegal, m_fmt(ent[31:0]) == 3'd7);
                    chk("sb_tag32", out_tag, ent[39:32]);
                    chk("sb_tag64", q_out_tag, ent[39:32]);
                end
            end
            if (in_valid && in_ready) begin
                n_acc++;
                sb_q.push_back({in_tag, in_instr});
            end
            stall_prev = out_valid && !out_ready;
            h_imm32 = out_imm;
            h_imm64 = q_out_imm;
            h_fmt   = out_fmt;
            h_ill   = out_illegal;
            h_tag   = out_tag;
        end
    end

    task automatic single(input string nm, input logic [31:0] ins, input logic [7:0] tg,
                          input logic [63:0] e_imm, input logic [2:0] e_fmt, input logic e_ill);
        logic [31:0] e32;
        e32 = e_imm[31:0];
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = ins;
        in_tag    = tg;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, "_valid"}, out_valid, 1'b1);
        chk({nm, "_imm32"}, out_imm, e32);
        chk({nm, "_imm64"}, q_out_imm, e_imm);
        chk({nm, "_fmt"}, out_fmt, e_fmt);
        chk({nm, "_illegal"}, out_illegal, e_ill);
        chk({nm, "_tag"}, out_tag, tg);
        @(posedge clk); #1;
    endtask

    logic [6:0]  opcs [12] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                               7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h0B};
    logic [31:0] vec [100];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cyc;
        logic acc;
        logic [31:0] r;

        chk("model_addi", m_imm(32'hFFF00093), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("model_sw", m_imm(32'hFE112E23), 64'hFFFF_FFFF_FFFF_FFFC);
        chk("model_beq", m_imm(32'h00000463), 64'h8);
        chk("model_jal", m_imm(32'hFFDFF0EF), 64'hFFFF_FFFF_FFFF_FFFC);
        chk("model_lui", m_imm(32'h800002B7), 64'hFFFF_FFFF_8000_0000);

        repeat (2) @(posedge clk);
        #1 res = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_imm", out_imm, 32'h0);
        chk("rst_out_imm64", q_out_imm, 64'h0);
        chk("rst_out_fmt", out_fmt, 3'd0);
        chk("rst_out_illegal", out_illegal, 1'b0);
        chk("rst_out_tag", out_tag, 8'h0);

        single("addi",  32'hFFF00093, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
        single("sw",    32'hFE112E23, 8'h02, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
        single("beq",   32'h00000463, 8'h03, 64'h0000_0000_0000_0008, 3'd3, 1'b0);
        single("jal",   32'hFFDFF0EF, 8'h04, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0);
        single("lui",   32'h800002B7, 8'h05, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
        single("auipc", 32'h12345017, 8'h06, 64'h0000_0000_1234_5000, 3'd4, 1'b0);
        single("ill",   32'h0000007F, 8'h07, 64'h0, 3'd7, 1'b1);
        single("add",   32'h002081B3, 8'h08, 64'h0, 3'd0, 1'b0);

        // Backpressure: tags 1,2 buffered, tag 3 held upstream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        in_tag    = 8'd1;
        @(posedge clk); #1;
        in_instr = 32'h00200093;
        in_tag   = 8'd2;
        @(posedge clk); #1;
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_head_tag", out_tag, 8'd1);
        in_instr = 32'h00300093;
        in_tag   = 8'd3;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_tag", out_tag, 8'd1);
        chk("bp_hold_imm", out_imm, 32'd1);
        chk("bp_hold_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_tag2", out_tag, 8'd2);
        chk("bp_rel_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_rel_tag3", out_tag, 8'd3);
        chk("bp_rel_imm3", out_imm, 32'd3);
        @(posedge clk); #1;
        chk("bp_drained", out_valid, 1'b0);

        // Streaming with random valid/ready.
        for (int k = 0; k < 100; k++) begin
            r = $urandom();
            vec[k] = {r[31:7], opcs[$urandom_range(0, 11)]};
        end
        idx = 0;
        cyc = 0;
        while (idx < 100 && cyc < 3000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = vec[idx];
            in_tag    = 8'(idx);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_all_accepted", 64'(idx), 64'd100);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("stream_drained", 64'(sb_q.size()), 64'd0);
        chk("stream_emit_count", 64'(n_emit), 64'(n_acc));

        // Reset with two entries buffered; inputs offered during reset are ignored.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00500093;
        in_tag    = 8'h10;
        @(posedge clk); #1;
        in_tag = 8'h11;
        @(posedge clk); #1;
        chk("mr_full", in_ready, 1'b0);
        res      = 1'b1;
        in_instr = 32'h00600093;
        in_tag   = 8'h12;
        @(posedge clk); #1;
        res      = 1'b0;
        in_valid = 1'b0;
        chk("mr_out_valid", out_valid, 1'b0);
        chk("mr_in_ready", in_ready, 1'b1);
        chk("mr_out_imm", out_imm, 32'h0);
        chk("mr_out_imm64", q_out_imm, 64'h0);
        chk("mr_out_fmt", out_fmt, 3'd0);
        chk("mr_out_illegal", out_illegal, 1'b0);
        chk("mr_out_tag", out_tag, 8'h0);
        @(posedge clk); #1;
        chk("mr_idle_valid", out_valid, 1'b0);
        single("post_rst", 32'h00700093, 8'h20, 64'h7, 3'd1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_empty", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
